// File: rtl/ahb_sramc_ctrl.sv
// AHB-Lite slave front end for a 2-bank x 4-lane array of 8Kx8 SRAM macros.
// Address phase is decoded into bank/lane chip selects and a word address.
// Writes commit in the data phase. Reads return with zero wait states, except
// a read that follows a write, which takes one wait state.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no data phase pending for this slave
//   WDATA   | write data phase; SRAM written from registered address info
//   RDATA   | read data phase; SRAM outputs returned on hrdata
//   RSTALL  | read deferred behind a write; issued now, hreadyout=0
//   ERR1    | first ERROR response cycle, hreadyout=0
//   ERR2    | second ERROR response cycle, hreadyout=1
module ahb_sramc_ctrl #(
  parameter int AW = 13,
  parameter int DW = 32
) (
  input  logic          sram_clk,
  input  logic          sram_rst,
  input  logic          hsel,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [15:0]   haddr,
  input  logic [DW-1:0] hwdata,
  input  logic          hready,
  output logic          hreadyout,
  output logic          hresp,
  output logic [DW-1:0] hrdata,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  output logic          sram_we,
  output logic [3:0]    bank0_cs,
  output logic [3:0]    bank1_cs,
  input  logic [7:0]    sram_b0,
  input  logic [7:0]    sram_b1,
  input  logic [7:0]    sram_b2,
  input  logic [7:0]    sram_b3,
  input  logic [7:0]    sram_b4,
  input  logic [7:0]    sram_b5,
  input  logic [7:0]    sram_b6,
  input  logic [7:0]    sram_b7
);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_RDATA, S_RSTALL, S_ERR1, S_ERR2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [3:0]    wr_lanes_q, wr_lanes_d;

  logic          accept;
  logic          illegal;
  logic          rd_direct;
  logic [3:0]    lanes;
  logic [3:0]    cs;
  logic          cs_bank;
  logic          htrans_lsb_unused;

  // SEQ and NONSEQ are treated alike; only htrans[1] matters.
  assign htrans_lsb_unused = htrans[0];
  assign accept = hsel & htrans[1] & hready;

  // Decode size/alignment into a byte-lane mask and a legality flag.
  always_comb begin
    lanes   = 4'b1111;
    illegal = 1'b0;
    case (hsize)
      3'd0: lanes = 4'b0001 << haddr[1:0];
      3'd1: begin
        lanes   = haddr[1] ? 4'b1100 : 4'b0011;
        illegal = haddr[0];
      end
      3'd2:    illegal = (haddr[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  // Next state, and capture of address-phase info for the coming data phase.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    wr_bank_d  = wr_bank_q;
    wr_lanes_d = wr_lanes_q;
    rd_addr_d  = rd_addr_q;
    rd_bank_d  = rd_bank_q;
    case (state_q)
      S_RSTALL: state_d = S_RDATA;
      S_ERR1:   state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          if (illegal) begin
            state_d = S_ERR1;
          end else if (hwrite) begin
            state_d    = S_WDATA;
            wr_addr_d  = haddr[2 +: AW];
            wr_bank_d  = haddr[15];
            wr_lanes_d = lanes;
          end else begin
            // The SRAM port belongs to the write this cycle; defer the read.
            state_d   = (state_q == S_WDATA) ? S_RSTALL : S_RDATA;
            rd_addr_d = haddr[2 +: AW];
            rd_bank_d = haddr[15];
          end
        end
      end
    endcase
  end

  // State and pending-transfer registers.
  always_ff @(posedge sram_clk) begin
    if (sram_rst) begin
      state_q    <= S_IDLE;
      wr_addr_q  <= '0;
      wr_bank_q  <= 1'b0;
      wr_lanes_q <= 4'b0;
      rd_addr_q  <= '0;
      rd_bank_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      wr_bank_q  <= wr_bank_d;
      wr_lanes_q <= wr_lanes_d;
      rd_addr_q  <= rd_addr_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  // A legal read accepted outside a write data phase uses the port in its own address cycle.
  assign rd_direct = accept & ~illegal & ~hwrite &
                     (state_q inside {S_IDLE, S_RDATA, S_ERR2});

  // SRAM port drive; forced idle under reset so an in-flight write is dropped.
  always_comb begin
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    cs         = 4'b0;
    cs_bank    = 1'b0;
    if (!sram_rst) begin
      if (state_q == S_WDATA) begin
        sram_we    = 1'b1;
        sram_addr  = wr_addr_q;
        sram_wdata = hwdata;
        cs         = wr_lanes_q;
        cs_bank    = wr_bank_q;
      end else if (state_q == S_RSTALL) begin
        sram_addr = rd_addr_q;
        cs        = 4'b1111;
        cs_bank   = rd_bank_q;
      end else if (rd_direct) begin
        sram_addr = haddr[2 +: AW];
        cs        = 4'b1111;
        cs_bank   = haddr[15];
      end
    end
  end

  assign bank0_cs = cs_bank ? 4'b0 : cs;
  assign bank1_cs = cs_bank ? cs : 4'b0;

  // Bus response; reads always return the full word of the selected bank.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = '0;
    if (!sram_rst) begin
      hreadyout = !(state_q inside {S_RSTALL, S_ERR1});
      hresp     = (state_q inside {S_ERR1, S_ERR2});
      if (state_q == S_RDATA)
        hrdata = rd_bank_q ? {sram_b7, sram_b6, sram_b5, sram_b4}
                           : {sram_b3, sram_b2, sram_b1, sram_b0};
    end
  end

endmodule

// File: tb/tb_ahb_sramc_ctrl.sv
// Bench for ahb_sramc_ctrl: behavioural SRAM macros, a transaction-level
// reference model (64 KB byte array plus per-transfer wait/response rules),
// directed scenarios and a randomized transfer mix.
module tb_ahb_sramc_ctrl;

  logic        sram_clk = 1'b0;
  logic        sram_rst;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [15:0] haddr;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_we;
  logic [3:0]  bank0_cs;
  logic [3:0]  bank1_cs;
  logic [7:0]  sb [8];
  logic        ext_rdy;
  logic        init_en;

  always #5 sram_clk = ~sram_clk;

  assign hready = hreadyout & ext_rdy;

  ahb_sramc_ctrl #(.AW(13), .DW(32)) dut (
    .sram_clk(sram_clk), .sram_rst(sram_rst), .hsel(hsel), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .haddr(haddr), .hwdata(hwdata),
    .hready(hready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
    .bank0_cs(bank0_cs), .bank1_cs(bank1_cs),
    .sram_b0(sb[0]), .sram_b1(sb[1]), .sram_b2(sb[2]), .sram_b3(sb[3]),
    .sram_b4(sb[4]), .sram_b5(sb[5]), .sram_b6(sb[6]), .sram_b7(sb[7])
  );

  // Initial memory contents, shared by the macros and the reference model.
  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ {a[14:8], a[15]} ^ 8'h3C;
  endfunction

  // Eight synchronous 8Kx8 macros; macro m = bank*4 + lane.
  logic [7:0] mac [8][8192];
  always @(posedge sram_clk) begin
    if (init_en) begin
      for (int m = 0; m < 8; m++) begin
        sb[m] <= 8'h00;
        for (int w = 0; w < 8192; w++)
          mac[m][w] <= pat({m[2], w[12:0], m[1:0]});
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (bank0_cs[n]) begin
          if (sram_we) mac[n][sram_addr] <= sram_wdata[8*n +: 8];
          else         sb[n] <= mac[n][sram_addr];
        end
        if (bank1_cs[n]) begin
          if (sram_we) mac[n+4][sram_addr] <= sram_wdata[8*n +: 8];
          else         sb[n+4] <= mac[n+4][sram_addr];
        end
      end
    end
  end

  typedef struct packed {
    logic        hsel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [15:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic [7:0]  ref_mem [65536];
  txn_t        dp;
  logic        dp_ours, dp_err;
  int          dp_waits, dp_cyc;
  int          n_pass = 0, n_total = 0;
  int          n_wait_obs = 0, n_err_obs = 0;
  logic [3:0]  last_wr_cs0, last_wr_cs1, last_rd_cs0, last_rd_cs1;
  logic [12:0] last_wr_addr, last_rd_addr;
  logic [31:0] last_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic txn_t mk(input logic s, input logic [1:0] tr, input logic w,
                              input logic [2:0] sz, input logic [15:0] a, input logic [31:0] d);
    txn_t t;
    t.hsel = s; t.trans = tr; t.wr = w; t.size = sz; t.addr = a; t.wdata = d;
    return t;
  endfunction

  function automatic logic is_illegal(input txn_t t);
    return (t.size > 3'd2) || (t.size == 3'd1 && t.addr[0]) ||
           (t.size == 3'd2 && t.addr[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] lanes_of(input txn_t t);
    if (t.size == 3'd0) return 4'b0001 << t.addr[1:0];
    if (t.size == 3'd1) return t.addr[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] mword(input logic [15:0] a);
    int b;
    b = int'({a[15:2], 2'b00});
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic commit(input txn_t t);
    int b;
    logic [3:0] m;
    b = int'({t.addr[15:2], 2'b00});
    m = lanes_of(t);
    for (int n = 0; n < 4; n++)
      if (m[n]) ref_mem[b+n] = t.wdata[8*n +: 8];
  endtask

  // One clock: drive address phase t, check every output against the model,
  // then advance the model if the address phase was taken.
  task automatic bus_cycle(input txn_t t, input logic want_lo, output logic done);
    logic ready_e, acc_now, prev_w, we_e, rdv;
    logic [12:0] addr_e;
    logic [3:0]  cs0_e, cs1_e;
    logic [31:0] wd_e, rd_e;
    hsel = t.hsel; htrans = t.trans; hwrite = t.wr; hsize = t.size; haddr = t.addr;
    hwdata = (dp_ours && !dp_err && dp.wr) ? dp.wdata : $urandom;
    ext_rdy = !(want_lo && !dp_ours);
    ready_e = (dp_cyc >= dp_waits);
    acc_now = t.hsel && t.trans[1] && ready_e && ext_rdy;
    we_e = 1'b0; addr_e = '0; cs0_e = '0; cs1_e = '0; wd_e = '0; rd_e = '0;
    if (dp_ours && !dp_err && dp.wr) begin
      we_e = 1'b1; addr_e = dp.addr[14:2]; wd_e = dp.wdata;
      if (dp.addr[15]) cs1_e = lanes_of(dp); else cs0_e = lanes_of(dp);
    end else if (dp_ours && !dp_err && !dp.wr && dp_waits == 1 && dp_cyc == 0) begin
      addr_e = dp.addr[14:2];
      if (dp.addr[15]) cs1_e = 4'hF; else cs0_e = 4'hF;
    end else if (acc_now && !is_illegal(t) && !t.wr) begin
      addr_e = t.addr[14:2];
      if (t.addr[15]) cs1_e = 4'hF; else cs0_e = 4'hF;
    end
    rdv = dp_ours && !dp_err && !dp.wr && (dp_cyc == dp_waits);
    if (rdv) rd_e = mword(dp.addr);
    @(negedge sram_clk);
    chk("hreadyout", 32'(hreadyout), 32'(ready_e));
    chk("hresp", 32'(hresp), 32'(dp_ours && dp_err));
    chk("hrdata", hrdata, rd_e);
    chk("sram_we", 32'(sram_we), 32'(we_e));
    chk("sram_addr", 32'(sram_addr), 32'(addr_e));
    chk("bank0_cs", 32'(bank0_cs), 32'(cs0_e));
    chk("bank1_cs", 32'(bank1_cs), 32'(cs1_e));
    chk("sram_wdata", sram_wdata, wd_e);
    if (!hreadyout) n_wait_obs++;
    if (hresp) n_err_obs++;
    if (we_e) begin
      last_wr_cs0 = bank0_cs; last_wr_cs1 = bank1_cs; last_wr_addr = sram_addr;
    end else if (cs0_e != 4'h0 || cs1_e != 4'h0) begin
      last_rd_cs0 = bank0_cs; last_rd_cs1 = bank1_cs; last_rd_addr = sram_addr;
    end
    if (rdv) last_rdata = hrdata;
    @(posedge sram_clk);
    if (ready_e && ext_rdy) begin
      if (dp_ours && !dp_err && dp.wr) commit(dp);
      prev_w   = dp_ours && !dp_err && dp.wr;
      dp       = t;
      dp_ours  = t.hsel && t.trans[1];
      dp_err   = dp_ours && is_illegal(t);
      dp_waits = (dp_err || (dp_ours && !t.wr && prev_w)) ? 1 : 0;
      dp_cyc   = 0;
      done     = 1'b1;
    end else begin
      dp_cyc++;
      done = 1'b0;
    end
    #1;
  endtask

  task automatic issue(input txn_t t, input logic want_lo = 1'b0);
    logic done;
    logic lo;
    lo = want_lo;
    for (int i = 0; i < 5; i++) begin
      bus_cycle(t, lo, done);
      lo = 1'b0;
      if (done) return;
    end
    n_total++;
    $display("FAIL issue_timeout: address phase at %h not taken within 5 cycles", t.addr);
  endtask

  task automatic idle();
    issue(mk(1'b0, 2'b00, 1'b0, 3'd0, 16'h0, 32'h0));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, e0;
    txn_t t;
    for (int a = 0; a < 65536; a++) ref_mem[a] = pat(16'(a));
    dp = '0; dp_ours = 1'b0; dp_err = 1'b0; dp_waits = 0; dp_cyc = 0;
    last_rdata = '0;
    sram_rst = 1'b1; init_en = 1'b1; ext_rdy = 1'b1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; haddr = '0; hwdata = '0;
    repeat (2) @(posedge sram_clk);
    @(negedge sram_clk);
    chk("rst_hreadyout", 32'(hreadyout), 32'h1);
    chk("rst_hresp", 32'(hresp), 32'h0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_we", 32'(sram_we), 32'h0);
    chk("rst_cs", 32'({bank1_cs, bank0_cs}), 32'h0);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_wdata", sram_wdata, 32'h0);
    @(posedge sram_clk); #1;
    sram_rst = 1'b0; init_en = 1'b0;

    // Word write then word read, separated by an idle: no waits.
    w0 = n_wait_obs;
    issue(mk(1, 2'b10, 1, 3'd2, 16'h0004, 32'hDEADBEEF));
    idle();
    issue(mk(1, 2'b10, 0, 3'd2, 16'h0004, 32'h0));
    idle();
    chk("t1_wr_cs0", 32'(last_wr_cs0), 32'hF);
    chk("t1_wr_cs1", 32'(last_wr_cs1), 32'h0);
    chk("t1_wr_addr", 32'(last_wr_addr), 32'h1);
    chk("t1_rd_cs0", 32'(last_rd_cs0), 32'hF);
    chk("t1_rd_addr", 32'(last_rd_addr), 32'h1);
    chk("t1_rdata", last_rdata, 32'hDEADBEEF);
    chk("t1_model_pin", mword(16'h0004), 32'hDEADBEEF);
    chk("t1_waits", 32'(n_wait_obs - w0), 32'h0);

    // Byte then half write into bank 1, word readback.
    issue(mk(1, 2'b10, 1, 3'd0, 16'h8001, 32'h0000A500));
    issue(mk(1, 2'b10, 1, 3'd1, 16'h8002, 32'h12340000));
    chk("t2_byte_cs1", 32'(last_wr_cs1), 32'h2);
    idle();
    chk("t2_half_cs1", 32'(last_wr_cs1), 32'hC);
    chk("t2_half_cs0", 32'(last_wr_cs0), 32'h0);
    issue(mk(1, 2'b10, 0, 3'd2, 16'h8000, 32'h0));
    idle();
    chk("t2_rdata_hi", 32'(last_rdata[31:8]), 32'h1234A5);
    chk("t2_model_pin", 32'(mword(16'h8000) >> 8), 32'h1234A5);

    // Write immediately followed by reads: exactly one wait.
    w0 = n_wait_obs;
    issue(mk(1, 2'b10, 1, 3'd2, 16'h0010, 32'hCAFE0010));
    issue(mk(1, 2'b10, 0, 3'd2, 16'h0020, 32'h0));
    issue(mk(1, 2'b11, 0, 3'd2, 16'h0010, 32'h0));
    idle();
    chk("t3_waits", 32'(n_wait_obs - w0), 32'h1);
    chk("t3_rdata", last_rdata, 32'hCAFE0010);
    issue(mk(1, 2'b10, 1, 3'd2, 16'h0010, 32'h0BADF00D));
    issue(mk(1, 2'b10, 0, 3'd0, 16'h0013, 32'h0));
    idle();
    chk("t3_waits2", 32'(n_wait_obs - w0), 32'h2);
    chk("t3_rdata_new", last_rdata, 32'h0BADF00D);

    // Two illegal transfers, then legal write/read complete OKAY.
    w0 = n_wait_obs; e0 = n_err_obs;
    issue(mk(1, 2'b10, 1, 3'd2, 16'h0002, 32'h11111111));
    issue(mk(1, 2'b10, 0, 3'd3, 16'h0040, 32'h0));
    issue(mk(1, 2'b10, 1, 3'd2, 16'h0040, 32'h40404040));
    issue(mk(1, 2'b10, 0, 3'd2, 16'h0040, 32'h0));
    idle();
    chk("t4_err_cycles", 32'(n_err_obs - e0), 32'h4);
    chk("t4_waits", 32'(n_wait_obs - w0), 32'h3);
    chk("t4_rdata", last_rdata, 32'h40404040);

    // Reset during a write data phase drops the write.
    issue(mk(1, 2'b10, 1, 3'd2, 16'h0100, 32'h55AA55AA));
    idle();
    issue(mk(1, 2'b10, 1, 3'd2, 16'h0100, 32'hFFFF0000));
    sram_rst = 1'b1; hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF0000; ext_rdy = 1'b1;
    @(negedge sram_clk);
    chk("t5_we", 32'(sram_we), 32'h0);
    chk("t5_cs", 32'({bank1_cs, bank0_cs}), 32'h0);
    chk("t5_hreadyout", 32'(hreadyout), 32'h1);
    chk("t5_hresp", 32'(hresp), 32'h0);
    chk("t5_wdata", sram_wdata, 32'h0);
    @(posedge sram_clk); #1;
    sram_rst = 1'b0;
    dp = '0; dp_ours = 1'b0; dp_err = 1'b0; dp_waits = 0; dp_cyc = 0;
    issue(mk(1, 2'b10, 0, 3'd2, 16'h0100, 32'h0));
    idle();
    chk("t5_kept_old", last_rdata, 32'h55AA55AA);

    // Random mix over a small hot region to force collisions.
    for (int k = 0; k < 1500; k++) begin
      t.hsel  = ($urandom_range(0, 9) != 0);
      t.trans = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1))
                                            : (2'b10 | 2'($urandom_range(0, 1)));
      t.wr    = 1'($urandom_range(0, 1));
      t.size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7))
                                             : 3'($urandom_range(0, 2));
      t.addr  = {1'($urandom_range(0, 1)), 8'h00, 7'($urandom)};
      if ($urandom_range(0, 15) != 0) begin
        if (t.size == 3'd1) t.addr[0] = 1'b0;
        if (t.size == 3'd2) t.addr[1:0] = 2'b00;
      end
      t.wdata = $urandom;
      issue(t, ($urandom_range(0, 7) == 0));
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
